// File: rtl/ex_flag_stage_if.sv
// EX-stage to EX/MEM boundary signal bundle: instruction fields in, latched fields, flags and branch condition out.
// An instruction commits when ex_valid is high and neither stall nor flush is asserted; stall holds the latch, flush inserts a bubble.
interface ex_flag_stage_if;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [15:0] ex_result;
    logic [3:0]  ex_rd;
    logic        ex_wr_en;
    logic        stall;
    logic        flush;
    logic [2:0]  ccc;
    logic        mem_valid;
    logic [3:0]  mem_opcode;
    logic [15:0] mem_result;
    logic [3:0]  mem_rd;
    logic        mem_wr_en;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        cond_true;

    modport master (
        output ex_valid, ex_opcode, ex_a, ex_b, ex_result, ex_rd, ex_wr_en,
        output stall, flush, ccc,
        input  mem_valid, mem_opcode, mem_result, mem_rd, mem_wr_en,
        input  flag_z, flag_v, flag_n, cond_true
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_a, ex_b, ex_result, ex_rd, ex_wr_en,
        input  stall, flush, ccc,
        output mem_valid, mem_opcode, mem_result, mem_rd, mem_wr_en,
        output flag_z, flag_v, flag_n, cond_true
    );
endinterface

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline latch plus the Z/V/N flag register and the same-cycle branch condition evaluator.
module ex_flag_stage (
    input  logic            clk,
    input  logic            rst,
    ex_flag_stage_if.slave  bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic        mem_valid_q, mem_valid_d;
    logic [3:0]  mem_opcode_q, mem_opcode_d;
    logic [15:0] mem_result_q, mem_result_d;
    logic [3:0]  mem_rd_q, mem_rd_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_v_q, flag_v_d;
    logic        flag_n_q, flag_n_d;

    logic        advance;
    logic        sets_zvn;
    logic        sets_z;
    logic [16:0] a_ext, b_ext, exact_sum;
    logic        z_new, v_new, n_new;
    logic        fz, fv, fn;
    logic        cond;

    // Overflow comes from the exact 17-bit sum because ex_result may already be saturated.
    always_comb begin
        advance   = bus.ex_valid & ~bus.stall & ~bus.flush;
        sets_zvn  = (bus.ex_opcode == OP_ADD) | (bus.ex_opcode == OP_SUB);
        sets_z    = sets_zvn | (bus.ex_opcode == OP_XOR) | (bus.ex_opcode == OP_SLL) |
                    (bus.ex_opcode == OP_SRA) | (bus.ex_opcode == OP_ROR);
        a_ext     = {bus.ex_a[15], bus.ex_a};
        b_ext     = {bus.ex_b[15], bus.ex_b};
        exact_sum = (bus.ex_opcode == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
        v_new     = exact_sum[16] ^ exact_sum[15];
        z_new     = (bus.ex_result == 16'h0000);
        n_new     = bus.ex_result[15];

        fz = (advance & sets_z)   ? z_new : flag_z_q;
        fv = (advance & sets_zvn) ? v_new : flag_v_q;
        fn = (advance & sets_zvn) ? n_new : flag_n_q;

        flag_z_d = fz;
        flag_v_d = fv;
        flag_n_d = fn;
    end

    // Stall outranks flush so a held instruction is never lost to a squash.
    always_comb begin
        mem_valid_d  = mem_valid_q;
        mem_opcode_d = mem_opcode_q;
        mem_result_d = mem_result_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_en_d  = mem_wr_en_q;
        if (bus.stall) begin
            mem_valid_d = mem_valid_q;
        end else if (bus.flush) begin
            mem_valid_d  = 1'b0;
            mem_opcode_d = 4'h0;
            mem_result_d = 16'h0000;
            mem_rd_d     = 4'h0;
            mem_wr_en_d  = 1'b0;
        end else begin
            mem_valid_d  = bus.ex_valid;
            mem_opcode_d = bus.ex_opcode;
            mem_result_d = bus.ex_result;
            mem_rd_d     = bus.ex_rd;
            mem_wr_en_d  = bus.ex_wr_en & bus.ex_valid;
        end
    end

    always_comb begin
        cond = 1'b1;
        unique case (bus.ccc)
            3'b000: cond = ~fz;
            3'b001: cond = fz;
            3'b010: cond = ~fz & ~fn;
            3'b011: cond = fn;
            3'b100: cond = fz | ~fn;
            3'b101: cond = fn | fz;
            3'b110: cond = fv;
            3'b111: cond = 1'b1;
            default: cond = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q  <= 1'b0;
            mem_opcode_q <= 4'h0;
            mem_result_q <= 16'h0000;
            mem_rd_q     <= 4'h0;
            mem_wr_en_q  <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_v_q     <= 1'b0;
            flag_n_q     <= 1'b0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            mem_opcode_q <= mem_opcode_d;
            mem_result_q <= mem_result_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_en_q  <= mem_wr_en_d;
            flag_z_q     <= flag_z_d;
            flag_v_q     <= flag_v_d;
            flag_n_q     <= flag_n_d;
        end
    end

    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_opcode = mem_opcode_q;
    assign bus.mem_result = mem_result_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr_en  = mem_wr_en_q;
    assign bus.flag_z     = flag_z_q;
    assign bus.flag_v     = flag_v_q;
    assign bus.flag_n     = flag_n_q;
    assign bus.cond_true  = cond;
endmodule

// File: tb/tb_ex_flag_stage.sv
// Vector-table bench for ex_flag_stage: each row drives one cycle, checks cond_true in-cycle and the latched outputs after the edge.
module tb_ex_flag_stage;
    typedef struct {
        logic        rst;
        logic        valid;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  rd;
        logic        wr;
        logic        stall;
        logic        flush;
        logic [2:0]  ccc;
        logic        exp_cond;
        logic [28:0] exp_out;
    } vec_t;

    logic clk;
    logic rst;
    ex_flag_stage_if bus ();

    ex_flag_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [28:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    vec_t tbl[12];
    vec_t seq[10];

    // Expected latch word: {valid, opcode, result, rd, wr_en, z, v, n}.
    function automatic logic [28:0] pk(input logic v, input logic [3:0] op, input logic [15:0] r,
                                       input logic [3:0] rd, input logic wr,
                                       input logic z, input logic ov, input logic n);
        return {v, op, r, rd, wr, z, ov, n};
    endfunction

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] op,
                                input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                                input logic [3:0] rd, input logic wr, input logic st, input logic fl,
                                input logic [2:0] ccc, input logic ec, input logic [28:0] eo);
        vec_t t;
        t.rst = r; t.valid = v; t.op = op; t.a = a; t.b = b; t.res = res; t.rd = rd;
        t.wr = wr; t.stall = st; t.flush = fl; t.ccc = ccc; t.exp_cond = ec; t.exp_out = eo;
        return t;
    endfunction

    function automatic logic [28:0] actual_out();
        return {bus.mem_valid, bus.mem_opcode, bus.mem_result, bus.mem_rd, bus.mem_wr_en,
                bus.flag_z, bus.flag_v, bus.flag_n};
    endfunction

    task automatic check_out(input string name);
        logic [28:0] exp_w;
        logic [28:0] act_w;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            exp_w = exp_q.pop_front();
            act_w = actual_out();
            if (act_w !== exp_w) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, act_w, exp_w);
            end
        end
    endtask

    task automatic apply(input vec_t t, input string name);
        rst           = t.rst;
        bus.ex_valid  = t.valid;
        bus.ex_opcode = t.op;
        bus.ex_a      = t.a;
        bus.ex_b      = t.b;
        bus.ex_result = t.res;
        bus.ex_rd     = t.rd;
        bus.ex_wr_en  = t.wr;
        bus.stall     = t.stall;
        bus.flush     = t.flush;
        bus.ccc       = t.ccc;
        #1;
        checks++;
        if (bus.cond_true !== t.exp_cond) begin
            errors++;
            $display("FAIL %s cond: got %b expected %b", name, bus.cond_true, t.exp_cond);
        end
        exp_q.push_back(t.exp_out);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //           rst valid op     a        b        res      rd    wr  st  fl  ccc    cond  expected latch/flags
        tbl[0]  = mk(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 0, 0, 0, 3'b111, 1, pk(0, 4'h0, 16'h0000, 4'h0, 0, 0, 0, 0));
        tbl[1]  = mk(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 0, 0, 0, 3'b001, 0, pk(0, 4'h0, 16'h0000, 4'h0, 0, 0, 0, 0));
        tbl[2]  = mk(0, 1, 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 4'h1, 1, 0, 0, 3'b110, 1, pk(1, 4'h0, 16'h7FFF, 4'h1, 1, 0, 1, 0));
        tbl[3]  = mk(0, 1, 4'h1, 16'h8000, 16'h0001, 16'h8000, 4'h2, 1, 0, 0, 3'b011, 1, pk(1, 4'h1, 16'h8000, 4'h2, 1, 0, 1, 1));
        tbl[4]  = mk(0, 1, 4'h2, 16'h1234, 16'h1234, 16'h0000, 4'h3, 1, 0, 0, 3'b001, 1, pk(1, 4'h2, 16'h0000, 4'h3, 1, 1, 1, 1));
        tbl[5]  = mk(0, 1, 4'h0, 16'h0001, 16'h0002, 16'h0003, 4'h4, 0, 0, 0, 3'b000, 1, pk(1, 4'h0, 16'h0003, 4'h4, 0, 0, 0, 0));
        tbl[6]  = mk(0, 1, 4'h7, 16'h0000, 16'h0000, 16'h0000, 4'h5, 1, 0, 0, 3'b001, 0, pk(1, 4'h7, 16'h0000, 4'h5, 1, 0, 0, 0));
        tbl[7]  = mk(0, 1, 4'h8, 16'h0000, 16'h0000, 16'h0000, 4'h6, 1, 0, 0, 3'b010, 1, pk(1, 4'h8, 16'h0000, 4'h6, 1, 0, 0, 0));
        tbl[8]  = mk(0, 1, 4'h3, 16'h0000, 16'h0000, 16'h8000, 4'h7, 1, 0, 0, 3'b011, 0, pk(1, 4'h3, 16'h8000, 4'h7, 1, 0, 0, 0));
        tbl[9]  = mk(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h8, 1, 0, 0, 3'b100, 1, pk(0, 4'h0, 16'h0000, 4'h8, 0, 0, 0, 0));
        tbl[10] = mk(0, 1, 4'h4, 16'h0000, 16'h0000, 16'h8000, 4'h9, 1, 0, 0, 3'b011, 0, pk(1, 4'h4, 16'h8000, 4'h9, 1, 0, 0, 0));
        tbl[11] = mk(0, 1, 4'h1, 16'h0005, 16'h0005, 16'h0000, 4'hA, 1, 0, 1, 3'b001, 0, pk(0, 4'h0, 16'h0000, 4'h0, 0, 0, 0, 0));

        // Stall/release, stall+flush hold, reset mid-stall, then post-reset condition codes.
        seq[0] = mk(0, 1, 4'h1, 16'h0005, 16'h0005, 16'h0000, 4'hB, 1, 0, 0, 3'b001, 1, pk(1, 4'h1, 16'h0000, 4'hB, 1, 1, 0, 0));
        seq[1] = mk(0, 1, 4'h0, 16'h0001, 16'h0001, 16'h0002, 4'hC, 1, 0, 0, 3'b001, 0, pk(1, 4'h0, 16'h0002, 4'hC, 1, 0, 0, 0));
        seq[2] = mk(0, 1, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'hD, 1, 1, 0, 3'b001, 0, pk(1, 4'h0, 16'h0002, 4'hC, 1, 0, 0, 0));
        seq[3] = seq[2];
        seq[4] = seq[2];
        seq[5] = mk(0, 1, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'hD, 1, 0, 0, 3'b001, 1, pk(1, 4'h0, 16'h0000, 4'hD, 1, 1, 0, 0));
        seq[6] = mk(0, 1, 4'h1, 16'h0005, 16'h0005, 16'h0000, 4'hE, 1, 1, 1, 3'b000, 0, pk(1, 4'h0, 16'h0000, 4'hD, 1, 1, 0, 0));
        seq[7] = mk(1, 1, 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 4'hF, 1, 1, 0, 3'b111, 1, pk(0, 4'h0, 16'h0000, 4'h0, 0, 0, 0, 0));
        seq[8] = mk(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 0, 0, 0, 3'b010, 1, pk(0, 4'h0, 16'h0000, 4'h0, 0, 0, 0, 0));
        seq[9] = mk(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 0, 0, 0, 3'b110, 0, pk(0, 4'h0, 16'h0000, 4'h0, 0, 0, 0, 0));

        rst = 1'b1;
        bus.ex_valid = 1'b1; bus.ex_opcode = 4'h1; bus.ex_a = 16'h1234; bus.ex_b = 16'h4321;
        bus.ex_result = 16'hBEEF; bus.ex_rd = 4'h5; bus.ex_wr_en = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.ccc = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(pk(0, 4'h0, 16'h0000, 4'h0, 0, 0, 0, 0));
        check_out("reset");

        for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("tbl%0d", i));
        for (int i = 0; i < 10; i++) apply(seq[i], $sformatf("seq%0d", i));

        // Random idle cycles after reset: flags must stay clear, cond follows fixed table.
        for (int i = 0; i < 8; i++) begin
            vec_t t;
            logic [2:0] c;
            c = 3'($urandom_range(0, 7));
            t = mk(0, 0, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom),
                   4'($urandom_range(0, 15)), 0, 0, 1, c,
                   (c == 3'b000) || (c == 3'b010) || (c == 3'b100) || (c == 3'b111),
                   pk(0, 4'h0, 16'h0000, 4'h0, 0, 0, 0, 0));
            apply(t, $sformatf("idle%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
